// File: rtl/core_pkg.sv
// Shared definitions for the core front end.
//   - fetch_state_e : fetch FSM state encoding
//   - NOP_INST_WORD : instruction register reset value (addi x0,x0,0)
//   - RESET_PC_DEFAULT : default PC after reset
//   - *_LSB/*_MSB : RV32 instruction field bit positions
//   - OPC_* : major opcode constants shared with the control unit
package core_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } fetch_state_e;

  localparam logic [31:0] NOP_INST_WORD    = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instruction field positions
  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int F3_LSB  = 12;
  localparam int F3_MSB  = 14;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;
  localparam int F7_LSB  = 25;
  localparam int F7_MSB  = 31;

  // Major opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;

  // True when the low two bits of a target address are not word aligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return |addr_lo;
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter for the fetch unit.
//   clk_i, rst_n_i        : clock, synchronous active-low reset
//   inc_i                 : advance pc by 4 (wraps at 2^XLEN)
//   redirect_valid_i/pc_i : load a new target; wins over inc_i
//   pc_o                  : current fetch address, always word aligned
//   misaligned_o          : registered one-cycle flag for an unaligned target
module pc_register
  import core_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            inc_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] pc_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            misaligned_q, misaligned_d;

  always_comb begin
    pc_d         = pc_q;
    misaligned_d = 1'b0;
    if (redirect_valid_i) begin
      // Low bits are forced to zero; the flag tells the core they were dropped.
      pc_d         = {redirect_pc_i[XLEN-1:2], 2'b00};
      misaligned_d = is_misaligned(redirect_pc_i[1:0]);
    end else if (inc_i) begin
      pc_d = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign pc_o         = pc_q;
  assign misaligned_o = misaligned_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one instruction-memory read at a time and
// holds the returned word for the control unit / datapath.
//   clk_i, rst_n_i          : clock, synchronous active-low reset
//   imem_req_valid_o/ready_i: read request handshake, imem_addr_o = pc
//   imem_rsp_valid_i/data_i : read response (valid only, no back-pressure)
//   redirect_valid_i/pc_i   : new PC from the branch unit, highest priority
//   inst_valid_o/ready_i    : instruction handshake towards decode
//   inst_o, inst_pc_o, inst_pc_plus4_o, field slices, misaligned_o
//
// state   | meaning
// S_IDLE  | one cycle after reset, no request
// S_REQ   | request presented at pc, waiting for acceptance
// S_WAIT  | request accepted, waiting for its response
// S_HOLD  | instruction register valid, waiting for consumer
// S_DRAIN | redirected while a request was in flight; drop next response
module instr_fetch_unit
  import core_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter logic [31:0]     NOP_INST = NOP_INST_WORD
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic [XLEN-1:0] inst_pc_plus4_o,
  output logic [6:0]      opcode_o,
  output logic [2:0]      fun3_o,
  output logic [6:0]      fun7_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic            misaligned_o
);

  fetch_state_e    state_q, state_d;
  logic            req_valid_q;
  logic            inst_valid_q;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic [XLEN-1:0] pc;
  logic            load_inst;
  logic            pc_inc;

  pc_register #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .inc_i            (pc_inc),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .pc_o             (pc),
    .misaligned_o     (misaligned_o)
  );

  // A redirect overrides every other event. Any request already accepted
  // when it arrives still owes a response, which must be swallowed.
  always_comb begin
    state_d   = state_q;
    load_inst = 1'b0;
    pc_inc    = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ: begin
        if (imem_req_ready_i) state_d = redirect_valid_i ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid_i) begin
          state_d = imem_rsp_valid_i ? S_REQ : S_DRAIN;
        end else if (imem_rsp_valid_i) begin
          state_d   = S_HOLD;
          load_inst = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid_i) begin
          state_d = S_REQ;
        end else if (inst_ready_i) begin
          state_d = S_REQ;
          pc_inc  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (imem_rsp_valid_i) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the next state.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= NOP_INST;
      inst_pc_q    <= RESET_PC;
    end else begin
      state_q      <= state_d;
      req_valid_q  <= (state_d == S_REQ);
      inst_valid_q <= (state_d == S_HOLD);
      if (load_inst) begin
        inst_q    <= imem_rsp_data_i;
        inst_pc_q <= pc;
      end
    end
  end

  assign imem_req_valid_o = req_valid_q;
  assign imem_addr_o      = pc;
  assign inst_valid_o     = inst_valid_q;
  assign inst_o           = inst_q;
  assign inst_pc_o        = inst_pc_q;
  assign inst_pc_plus4_o  = inst_pc_q + XLEN'(4);

  assign opcode_o = inst_q[OPC_MSB:OPC_LSB];
  assign fun3_o   = inst_q[F3_MSB:F3_LSB];
  assign fun7_o   = inst_q[F7_MSB:F7_LSB];
  assign rs1_o    = inst_q[RS1_MSB:RS1_LSB];
  assign rs2_o    = inst_q[RS2_MSB:RS2_LSB];
  assign rd_o     = inst_q[RD_MSB:RD_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic [31:0] inst_pc_plus4_o;
  logic [6:0]  opcode_o;
  logic [2:0]  fun3_o;
  logic [6:0]  fun7_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [4:0]  rd_o;
  logic        misaligned_o;

  always #5 clk_i = ~clk_i;

  instr_fetch_unit dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_addr_o      (imem_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o),
    .inst_pc_plus4_o  (inst_pc_plus4_o),
    .opcode_o         (opcode_o),
    .fun3_o           (fun3_o),
    .fun7_o           (fun7_o),
    .rs1_o            (rs1_o),
    .rs2_o            (rs2_o),
    .rd_o             (rd_o),
    .misaligned_o     (misaligned_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: architectural next-PC, expected flags, and a memory
  // holding at most one pending response.
  logic [31:0] model_pc;
  logic        exp_mis;
  logic        exp_inval_low;
  logic        pend_active;
  int          pend_cnt;
  logic [31:0] pend_addr;
  int          cyc;
  int          first_req_cyc;
  int          first_val_cyc;
  int          n_inst;
  logic        acc_seen;
  int          p_ready, p_iready, p_redir, lat_min, lat_max;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
  endfunction

  function automatic logic pct(input int p);
    return ($urandom_range(0, 99) < p);
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(0, 7))
      0: t = 32'h0000_0100;
      1: t = 32'h0000_0102;
      2: t = 32'h0000_0040;
      3: t = 32'hFFFF_FFFC;
      4: t = 32'hFFFF_FFF6;
      5: t = 32'h0000_0041;
      default: t = $urandom() & 32'h0000_0FFF;
    endcase
    return t;
  endfunction

  // One clock cycle: observe at the falling edge, then drive the inputs the
  // next rising edge will act on and advance the model accordingly.
  task automatic step();
    logic        acc, cons;
    logic [31:0] e;
    logic [31:0] tgt;
    @(negedge clk_i);
    cyc++;

    chk("misaligned", misaligned_o, exp_mis);
    if (exp_inval_low) chk("valid_drop", inst_valid_o, 1'b0);
    if (inst_valid_o) begin
      if (first_val_cyc < 0) first_val_cyc = cyc;
      e = mem_word(model_pc);
      chk("inst_pc", inst_pc_o, model_pc);
      chk("inst", inst_o, e);
      chk("pc_plus4", inst_pc_plus4_o, model_pc + 32'd4);
      chk("opcode", opcode_o, e[6:0]);
      chk("rd", rd_o, e[11:7]);
      chk("fun3", fun3_o, e[14:12]);
      chk("rs1", rs1_o, e[19:15]);
      chk("rs2", rs2_o, e[24:20]);
      chk("fun7", fun7_o, e[31:25]);
      chk("req_in_hold", imem_req_valid_o, 1'b0);
    end

    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = $urandom();
    if (pend_active) begin
      pend_cnt--;
      if (pend_cnt <= 0) begin
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = mem_word(pend_addr);
        pend_active      = 1'b0;
      end
    end
    imem_req_ready_i = pct(p_ready);
    inst_ready_i     = pct(p_iready);
    redirect_valid_i = pct(p_redir);
    tgt              = pick_target();
    redirect_pc_i    = redirect_valid_i ? tgt : $urandom();

    acc  = imem_req_valid_o && imem_req_ready_i;
    cons = inst_valid_o && inst_ready_i;
    if (acc) begin
      if (first_req_cyc < 0) first_req_cyc = cyc;
      chk("one_outstanding", pend_active, 1'b0);
      chk("imem_addr", imem_addr_o, model_pc);
      pend_active = 1'b1;
      pend_addr   = imem_addr_o;
      pend_cnt    = $urandom_range(lat_min, lat_max);
      acc_seen    = 1'b1;
    end

    exp_inval_low = cons || redirect_valid_i;
    if (redirect_valid_i) begin
      model_pc = {redirect_pc_i[31:2], 2'b00};
      exp_mis  = (redirect_pc_i[1:0] != 2'b00);
    end else begin
      exp_mis = 1'b0;
      if (cons) begin
        model_pc = model_pc + 32'd4;
        n_inst++;
      end
    end
  endtask

  task automatic model_reset();
    model_pc      = 32'h0;
    exp_mis       = 1'b0;
    exp_inval_low = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req_valid"}, imem_req_valid_o, 1'b0);
    chk({tag, "_inst_valid"}, inst_valid_o, 1'b0);
    chk({tag, "_inst"}, inst_o, 32'h0000_0013);
    chk({tag, "_inst_pc"}, inst_pc_o, 32'h0);
    chk({tag, "_addr"}, imem_addr_o, 32'h0);
    chk({tag, "_misaligned"}, misaligned_o, 1'b0);
  endtask

  initial begin
    int start_n;
    rst_n_i          = 1'b0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'h0;
    redirect_valid_i = 1'b0;
    redirect_pc_i    = 32'h0;
    inst_ready_i     = 1'b0;
    pend_active      = 1'b0;
    pend_cnt         = 0;
    pend_addr        = 32'h0;
    first_req_cyc    = -1;
    first_val_cyc    = -1;
    n_inst           = 0;
    acc_seen         = 1'b0;
    cyc              = 0;
    model_reset();

    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    cyc     = 0;
    check_reset_values("reset");

    // First fetch: memory always ready, 1-cycle latency, consumer stalled.
    p_ready = 100; p_iready = 0; p_redir = 0; lat_min = 1; lat_max = 1;
    repeat (10) step();
    chk("first_req_cycle", first_req_cyc, 1);
    chk("first_valid_cycle", first_val_cyc, 3);
    chk("first_opcode", opcode_o, 7'b001_0011);
    chk("first_rd", rd_o, 5'd1);
    chk("first_fun3", fun3_o, 3'd0);
    chk("first_plus4", inst_pc_plus4_o, 32'h4);

    // Release the consumer; next request must go to 0x4.
    p_iready = 100;
    repeat (6) step();
    chk("after_first_pc", (model_pc >= 32'h4), 1'b1);

    // Random traffic with redirects, stalls and variable latency.
    p_ready = 70; p_iready = 60; p_redir = 8; lat_min = 1; lat_max = 3;
    start_n = n_inst;
    repeat (4000) step();
    chk("progress", (n_inst - start_n > 200), 1'b1);

    // Reset while a request is outstanding; its late response must be ignored.
    p_ready = 100; p_iready = 100; p_redir = 0; lat_min = 3; lat_max = 3;
    acc_seen = 1'b0;
    for (int i = 0; i < 60 && !acc_seen; i++) step();
    chk("reset_setup_accept", acc_seen, 1'b1);
    @(negedge clk_i);
    cyc++;
    rst_n_i          = 1'b0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    redirect_valid_i = 1'b0;
    inst_ready_i     = 1'b0;
    if (pend_active) pend_cnt--;
    @(negedge clk_i);
    cyc++;
    check_reset_values("midreset");
    rst_n_i = 1'b1;
    if (pend_active) pend_cnt--;
    model_reset();
    start_n = n_inst;
    repeat (40) step();
    chk("post_reset_progress", (n_inst - start_n > 2), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
